// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives datapath enables and selects, counts retirements.
module multicycle_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  jump,
  output logic        branch,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int unsigned CW = 8;
  localparam int unsigned IW = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'b000,
    S_DECODE    = 3'b001,
    S_EXECUTE   = 3'b010,
    S_MEM       = 3'b011,
    S_WRITEBACK = 3'b100,
    S_TRAP      = 3'b101
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [IW-1:0]   r_instret;
  logic            r_illegal;
  logic            r_bus_err;

  state_t          w_next;
  logic [CW-1:0]   w_wait_next;
  logic            w_set_illegal;
  logic            w_set_bus_err;
  logic            w_imem_req, w_ir_write, w_dmem_req, w_mem_read, w_mem_write;
  logic            w_pc_write, w_reg_write, w_mem_to_reg, w_sel_en;
  logic            w_wait_expired;

  logic            w_legal;
  logic [1:0]      w_dec_alu_op;
  logic            w_dec_alu_src;
  logic [1:0]      w_dec_alu_a_sel;
  logic [1:0]      w_dec_jump;
  logic            w_dec_branch;

  logic            w_is_load, w_is_store, w_is_branch;

  assign w_is_load      = (opcode == OP_LOAD);
  assign w_is_store     = (opcode == OP_STORE);
  assign w_is_branch    = (opcode == OP_BR);
  // A ready in the same cycle as the limit is checked before this term, so it wins.
  assign w_wait_expired = (r_wait_cnt == CW'(WAIT_LIMIT - 1));

  // Opcode decode into ALU/jump/branch selects and legality.
  always_comb begin
    w_legal         = 1'b0;
    w_dec_alu_op    = 2'b00;
    w_dec_alu_src   = 1'b0;
    w_dec_alu_a_sel = 2'b00;
    w_dec_jump      = 2'b00;
    w_dec_branch    = 1'b0;
    case (opcode)
      OP_R:     begin w_legal = 1'b1; w_dec_alu_op = 2'b10; end
      OP_I:     begin w_legal = 1'b1; w_dec_alu_op = 2'b11; w_dec_alu_src = 1'b1; end
      OP_LOAD,
      OP_STORE: begin w_legal = 1'b1; w_dec_alu_src = 1'b1; end
      OP_BR:    begin w_legal = 1'b1; w_dec_alu_op = 2'b01; w_dec_branch = 1'b1; end
      OP_JAL:   begin w_legal = 1'b1; w_dec_jump = 2'b10; end
      OP_JALR:  begin w_legal = 1'b1; w_dec_jump = 2'b11; w_dec_alu_src = 1'b1; end
      OP_LUI:   begin w_legal = 1'b1; w_dec_alu_src = 1'b1; w_dec_alu_a_sel = 2'b10; end
      OP_AUIPC: begin w_legal = 1'b1; w_dec_alu_src = 1'b1; w_dec_alu_a_sel = 2'b01; end
      default:  w_legal = 1'b0;
    endcase
  end

  // State, wait counter, retirement counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_pc_write)    r_instret <= r_instret + IW'(1);
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  // Next state and per-state enables.
  always_comb begin
    w_next        = r_state;
    w_wait_next   = r_wait_cnt;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    w_imem_req    = 1'b0;
    w_ir_write    = 1'b0;
    w_dmem_req    = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_sel_en      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_wait_expired) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_wait_next = r_wait_cnt + CW'(1);
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_sel_en = 1'b1;
        if (w_is_branch) begin
          w_pc_write  = 1'b1;
          w_wait_next = '0;
          w_next      = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_wait_next = '0;
          w_next      = S_MEM;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_MEM: begin
        w_sel_en    = 1'b1;
        w_dmem_req  = 1'b1;
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
        if (dmem_ready) begin
          if (w_is_load) begin
            w_next = S_WRITEBACK;
          end else begin
            w_pc_write  = 1'b1;
            w_wait_next = '0;
            w_next      = S_FETCH;
          end
        end else if (w_wait_expired) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_wait_next = r_wait_cnt + CW'(1);
        end
      end
      S_WRITEBACK: begin
        w_sel_en     = 1'b1;
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_mem_to_reg = w_is_load;
        w_wait_next  = '0;
        w_next       = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Every output reads as zero while reset is held.
  assign imem_req   = rstn & w_imem_req;
  assign ir_write   = rstn & w_ir_write;
  assign dmem_req   = rstn & w_dmem_req;
  assign mem_read   = rstn & w_mem_read;
  assign mem_write  = rstn & w_mem_write;
  assign pc_write   = rstn & w_pc_write;
  assign reg_write  = rstn & w_reg_write;
  assign mem_to_reg = rstn & w_mem_to_reg;
  assign alu_op     = (rstn && w_sel_en) ? w_dec_alu_op    : 2'b00;
  assign alu_src    = rstn & w_sel_en & w_dec_alu_src;
  assign alu_a_sel  = (rstn && w_sel_en) ? w_dec_alu_a_sel : 2'b00;
  assign jump       = (rstn && w_sel_en) ? w_dec_jump      : 2'b00;
  assign branch     = rstn & w_sel_en & w_dec_branch;
  assign state      = rstn ? r_state   : 3'b000;
  assign illegal    = rstn & r_illegal;
  assign bus_err    = rstn & r_bus_err;
  assign instret    = rstn ? r_instret : 32'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm: the driver queues hand-computed
// per-cycle expectations; a negedge monitor pops and compares them against the outputs.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

  // ctl = {imem_req,ir_write,dmem_req,mem_read,mem_write,pc_write,reg_write,mem_to_reg,
  //        alu_op[1:0],alu_src,alu_a_sel[1:0],jump[1:0],branch}
  localparam logic [15:0] C_NONE   = 16'h0000;
  localparam logic [15:0] C_FWAIT  = 16'h8000;
  localparam logic [15:0] C_FRDY   = 16'hC000;
  localparam logic [15:0] C_LSEX   = 16'h0020;
  localparam logic [15:0] C_LDMEM  = 16'h3020;
  localparam logic [15:0] C_LDWB   = 16'h0720;
  localparam logic [15:0] C_STMEM  = 16'h2C20;
  localparam logic [15:0] C_STWAIT = 16'h2820;
  localparam logic [15:0] C_BREX   = 16'h0441;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  opcode;
  logic        imem_ready, dmem_ready;
  logic        imem_req, ir_write, dmem_req, mem_read, mem_write, pc_write;
  logic        reg_write, mem_to_reg, alu_src, branch, illegal, bus_err;
  logic [1:0]  alu_op, alu_a_sel, jump;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .mem_read(mem_read),
    .mem_write(mem_write), .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .alu_src(alu_src), .alu_a_sel(alu_a_sel), .jump(jump), .branch(branch),
    .state(state), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  logic [52:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  string       cur = "init";
  logic [52:0] m_exp, m_act;
  string       m_nm;

  // Drive one cycle of inputs and queue what the outputs must show in that cycle.
  task automatic step(input logic rn, input logic [6:0] op, input logic ir, input logic dr,
                      input logic [2:0] st, input logic [15:0] ctl, input logic ill,
                      input logic be, input logic [31:0] cnt);
    @(posedge clk); #1;
    rstn = rn; opcode = op; imem_ready = ir; dmem_ready = dr;
    exp_q.push_back({st, ctl, ill, be, cnt});
    name_q.push_back(cur);
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic [15:0] ex, input logic [15:0] wb,
                           input logic [31:0] cnt);
    step(1'b1, op, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, cnt);
    step(1'b1, op, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, cnt);
    step(1'b1, op, 1'b0, 1'b0, S_E, ex,     1'b0, 1'b0, cnt);
    step(1'b1, op, 1'b0, 1'b0, S_W, wb,     1'b0, 1'b0, cnt);
  endtask

  task automatic reset_cycle();
    step(1'b0, OP_R, 1'b1, 1'b1, S_F, C_NONE, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_nm  = name_q.pop_front();
        m_act = {state, imem_req, ir_write, dmem_req, mem_read, mem_write, pc_write, reg_write,
                 mem_to_reg, alu_op, alu_src, alu_a_sel, jump, branch, illegal, bus_err, instret};
        n_vec++;
        if (m_act !== m_exp) begin
          n_err++;
          $display("FAIL %s vec%0d: got state=%0d ctl=%04h ill=%0b be=%0b instret=%08h, want state=%0d ctl=%04h ill=%0b be=%0b instret=%08h",
                   m_nm, n_vec, m_act[52:50], m_act[49:34], m_act[33], m_act[32], m_act[31:0],
                   m_exp[52:50], m_exp[49:34], m_exp[33], m_exp[32], m_exp[31:0]);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0;

    cur = "reset";
    reset_cycle();
    reset_cycle();

    cur = "add";
    alu_instr(OP_R, 16'h0080, 16'h0680, 32'd0);

    cur = "lw_wait3";
    step(1'b1, OP_LOAD, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_E, C_LSEX, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, OP_LOAD, 1'b1, 1'b0, S_M, C_LDMEM, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_LOAD, 1'b0, 1'b1, S_M, C_LDMEM, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_W, C_LDWB,  1'b0, 1'b0, 32'd1);

    cur = "sw";
    step(1'b1, OP_STORE, 1'b1, 1'b1, S_F, C_FRDY,  1'b0, 1'b0, 32'd2);
    step(1'b1, OP_STORE, 1'b0, 1'b1, S_D, C_NONE,  1'b0, 1'b0, 32'd2);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_E, C_LSEX,  1'b0, 1'b0, 32'd2);
    step(1'b1, OP_STORE, 1'b0, 1'b1, S_M, C_STMEM, 1'b0, 1'b0, 32'd2);

    cur = "beq";
    step(1'b1, OP_BR, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd3);
    step(1'b1, OP_BR, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'd3);
    step(1'b1, OP_BR, 1'b0, 1'b0, S_E, C_BREX, 1'b0, 1'b0, 32'd3);

    cur = "addi";  alu_instr(OP_I,     16'h00E0, 16'h06E0, 32'd4);
    cur = "jal";   alu_instr(OP_JAL,   16'h0004, 16'h0604, 32'd5);
    cur = "jalr";  alu_instr(OP_JALR,  16'h0026, 16'h0626, 32'd6);
    cur = "lui";   alu_instr(OP_LUI,   16'h0030, 16'h0630, 32'd7);
    cur = "auipc"; alu_instr(OP_AUIPC, 16'h0028, 16'h0628, 32'd8);

    cur = "fetch_wait2";
    for (int i = 0; i < 2; i++) step(1'b1, OP_R, 1'b0, 1'b0, S_F, C_FWAIT, 1'b0, 1'b0, 32'd9);
    alu_instr(OP_R, 16'h0080, 16'h0680, 32'd9);

    cur = "illegal";
    step(1'b1, OP_BAD, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd10);
    step(1'b1, OP_BAD, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'd10);
    for (int i = 0; i < 20; i++) step(1'b1, OP_BAD, 1'b1, 1'b1, S_T, C_NONE, 1'b1, 1'b0, 32'd10);
    cur = "trap_reset";
    reset_cycle();
    alu_instr(OP_R, 16'h0080, 16'h0680, 32'd0);

    cur = "imem_timeout";
    for (int i = 0; i < 16; i++) step(1'b1, OP_R, 1'b0, 1'b1, S_F, C_FWAIT, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++)  step(1'b1, OP_R, 1'b1, 1'b1, S_T, C_NONE,  1'b0, 1'b1, 32'd1);
    reset_cycle();

    cur = "ready_on_16th";
    for (int i = 0; i < 15; i++) step(1'b1, OP_R, 1'b0, 1'b0, S_F, C_FWAIT, 1'b0, 1'b0, 32'd0);
    alu_instr(OP_R, 16'h0080, 16'h0680, 32'd0);

    cur = "dmem_timeout";
    step(1'b1, OP_STORE, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'd1);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_E, C_LSEX, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 16; i++) step(1'b1, OP_STORE, 1'b1, 1'b0, S_M, C_STWAIT, 1'b0, 1'b0, 32'd1);
    for (int i = 0; i < 2; i++)  step(1'b1, OP_STORE, 1'b1, 1'b1, S_T, C_NONE,   1'b0, 1'b1, 32'd1);
    reset_cycle();

    cur = "instret_wrap";
    step(1'b1, OP_R, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd0);
    step(1'b1, OP_R, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'hFFFF_FFFE);
    #2 dut.r_instret = 32'hFFFF_FFFE;
    step(1'b1, OP_R, 1'b0, 1'b0, S_E, 16'h0080, 1'b0, 1'b0, 32'hFFFF_FFFE);
    step(1'b1, OP_R, 1'b0, 1'b0, S_W, 16'h0680, 1'b0, 1'b0, 32'hFFFF_FFFE);
    alu_instr(OP_R, 16'h0080, 16'h0680, 32'hFFFF_FFFF);
    step(1'b1, OP_STORE, 1'b1, 1'b0, S_F, C_FRDY, 1'b0, 1'b0, 32'd0);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_D, C_NONE, 1'b0, 1'b0, 32'd0);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_E, C_LSEX, 1'b0, 1'b0, 32'd0);

    cur = "reset_in_mem";
    step(1'b0, OP_STORE, 1'b0, 1'b1, S_F, C_NONE, 1'b0, 1'b0, 32'd0);
    step(1'b1, OP_LOAD, 1'b1, 1'b0, S_F, C_FRDY,  1'b0, 1'b0, 32'd0);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_D, C_NONE,  1'b0, 1'b0, 32'd0);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_E, C_LSEX,  1'b0, 1'b0, 32'd0);
    step(1'b1, OP_LOAD, 1'b0, 1'b1, S_M, C_LDMEM, 1'b0, 1'b0, 32'd0);
    cur = "reset_in_wb";
    step(1'b0, OP_LOAD, 1'b0, 1'b0, S_F, C_NONE,  1'b0, 1'b0, 32'd0);
    step(1'b1, OP_R,    1'b0, 1'b0, S_F, C_FWAIT, 1'b0, 1'b0, 32'd0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
